// File: rtl/leglite_pkg.sv
// rtl/leglite_pkg.sv - shared state encoding and image-format constants for the LEGLite boot controller
package leglite_pkg;

  // Image framing: two length bytes, then data words, then one checksum byte.
  localparam int HDR_LEN        = 2;
  localparam int CSUM_W         = 8;
  localparam int IMEM_DEPTH_DEF = 64;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_LEN_HI  = 4'd1;
  localparam state_t ST_LEN_LO  = 4'd2;
  localparam state_t ST_DATA_HI = 4'd3;
  localparam state_t ST_DATA_LO = 4'd4;
  localparam state_t ST_CHECK   = 4'd5;
  localparam state_t ST_RUN     = 4'd6;
  localparam state_t ST_DONE    = 4'd7;
  localparam state_t ST_ERROR   = 4'd8;

endpackage

// File: rtl/leglite_halt_mon.sv
// rtl/leglite_halt_mon.sv - branch-to-self detector and saturating RUN-cycle counter
module leglite_halt_mon #(
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] iaddr,
  output logic [15:0] cycle_count,
  output logic        halt,
  output logic        limit
);

  logic [15:0] prev_q;
  logic [15:0] cnt_q;
  logic        cmp_en_q;

  // The first RUN cycle has no previous PC to compare against.
  assign halt  = enable & cmp_en_q & (iaddr == prev_q);
  // Flags the cycle whose increment brings the count to the limit.
  assign limit = enable & (cnt_q >= (MAX_CYCLES - 16'd1));
  assign cycle_count = cnt_q;

  // Track previous PC and count RUN cycles, saturating at the limit.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      prev_q   <= 16'd0;
      cnt_q    <= 16'd0;
      cmp_en_q <= 1'b0;
    end else if (enable) begin
      prev_q   <= iaddr;
      cmp_en_q <= 1'b1;
      if (cnt_q != MAX_CYCLES) cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/leglite_boot_ctrl.sv
// rtl/leglite_boot_ctrl.sv - streams a program image into IMEM, verifies it, runs the core until halt
module leglite_boot_ctrl
  import leglite_pkg::*;
#(
  parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_req,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] imem_waddr,
  output logic [15:0] imem_wdata,
  output logic        imem_we,
  output logic        cpu_reset,
  input  logic [15:0] iaddr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        timeout,
  output logic [15:0] cycle_count
);

  state_t              state_q, state_d;
  logic [15:0]         len_q;
  logic [15:0]         idx_q;
  logic [7:0]          hi_q;
  logic [CSUM_W-1:0]   sum_q;
  logic [15:0]         waddr_q, wdata_q;
  logic                we_q, cpu_reset_q, busy_q, done_q, error_q, timeout_q;
  logic                xfer, load_start, halt, limit, run;
  logic [15:0]         len_w;

  assign byte_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                      (state_q == ST_CHECK);
  assign xfer       = byte_valid & byte_ready;
  assign load_start = load_req & ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERROR));
  assign run        = (state_q == ST_RUN);
  assign len_w      = {len_q[15:8], byte_in};

  leglite_halt_mon #(.MAX_CYCLES(MAX_CYCLES)) u_halt_mon (
    .clock       (clock),
    .reset       (reset),
    .enable      (run),
    .clear       (load_start),
    .iaddr       (iaddr),
    .cycle_count (cycle_count),
    .halt        (halt),
    .limit       (limit)
  );

  // Next-state decode of the load/check/run sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (load_req) state_d = ST_LEN_HI;
      ST_LEN_HI:  if (xfer) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (xfer) begin
          if (len_w > 16'(IMEM_DEPTH)) state_d = ST_ERROR;
          else if (len_w == 16'd0)     state_d = ST_CHECK;
          else                         state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (xfer) state_d = ST_DATA_LO;
      ST_DATA_LO: if (xfer) state_d = (idx_q == len_q - 16'd1) ? ST_CHECK : ST_DATA_HI;
      ST_CHECK:   if (xfer) state_d = (byte_in == sum_q) ? ST_RUN : ST_ERROR;
      ST_RUN:     if (halt || limit) state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, image datapath and registered status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= 16'd0;
      idx_q       <= 16'd0;
      hi_q        <= 8'd0;
      sum_q       <= '0;
      waddr_q     <= 16'd0;
      wdata_q     <= 16'd0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERROR));
      cpu_reset_q <= (state_d != ST_RUN);
      we_q        <= 1'b0;
      if (load_start) begin
        done_q    <= 1'b0;
        error_q   <= 1'b0;
        timeout_q <= 1'b0;
        sum_q     <= '0;
        idx_q     <= 16'd0;
      end
      if (xfer) begin
        case (state_q)
          ST_LEN_HI: len_q[15:8] <= byte_in;
          ST_LEN_LO: len_q[7:0]  <= byte_in;
          ST_DATA_HI: begin
            hi_q  <= byte_in;
            sum_q <= sum_q + byte_in;
          end
          ST_DATA_LO: begin
            we_q    <= 1'b1;
            waddr_q <= idx_q;
            wdata_q <= {hi_q, byte_in};
            sum_q   <= sum_q + byte_in;
            idx_q   <= idx_q + 16'd1;
          end
          default: ;
        endcase
      end
      if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) error_q <= 1'b1;
      if (run && (state_d == ST_DONE)) begin
        done_q    <= 1'b1;
        timeout_q <= ~halt;
      end
    end
  end

  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign imem_we    = we_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign timeout    = timeout_q;

endmodule
